// File: rtl/centroid_ctrl.sv
// Blob centroid controller: accumulates mask pixel statistics per frame, then runs one
// shared restoring divider for x and y. Optional macro CENTROID_ROUND_EN selects round-to-nearest.
module centroid_ctrl #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int ACC_W  = 32,
    parameter int CNT_W  = 19
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_valid,
    input  logic        pix_sof,
    input  logic        pix_bit,
    output logic        pix_ready,
    output logic        busy,
    output logic        result_valid,
    output logic        found,
    output logic [10:0] x,
    output logic [10:0] y,
    output logic [2:0]  state_dbg
);

    localparam int COL_W  = $clog2(WIDTH);
    localparam int ROW_W  = $clog2(HEIGHT);
    localparam int ITER_W = $clog2(ACC_W);
    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(WIDTH - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(HEIGHT - 1);
    localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(ACC_W - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ACCUM = 3'd1,
        DIV_X = 3'd2,
        DIV_Y = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Handshake: a pixel transfers on a rising edge where pix_valid && pix_ready;
    // pix_ready depends only on state, never on pix_valid.
    state_t state_q, state_d;

    logic [COL_W-1:0]  col_q, col_base, col_nxt;
    logic [ROW_W-1:0]  row_q, row_base, row_nxt;
    logic [CNT_W-1:0]  count_q, count_nxt;
    logic [ACC_W-1:0]  sum_x_q, sum_x_nxt, sum_y_q, sum_y_nxt;
    logic [ACC_W-1:0]  dq_q, dq_nxt;
    logic [CNT_W-1:0]  rem_q, rem_nxt;
    logic [CNT_W:0]    rem_sh, rem_diff;
    logic              div_ge, unused_rem_msb;
    logic [ITER_W-1:0] iter_q;
    logic [10:0]       qx_q, qy_q;
    logic [ACC_W-1:0]  rnd_nxt, rnd_q;
    logic              accept, take, last_pix, div_last;

    assign accept   = pix_valid && pix_ready;
    assign take     = accept && (pix_sof || state_q == ACCUM);
    assign last_pix = (col_q == COL_LAST) && (row_q == ROW_LAST);
    assign div_last = (iter_q == ITER_LAST);

    // A start-of-frame pixel behaves as raster (0,0) with empty sums.
    assign col_base  = pix_sof ? '0 : col_q;
    assign row_base  = pix_sof ? '0 : row_q;
    assign col_nxt   = (col_base == COL_LAST) ? '0 : col_base + COL_W'(1);
    assign row_nxt   = (col_base == COL_LAST) ? row_base + ROW_W'(1) : row_base;
    assign count_nxt = (pix_sof ? '0 : count_q) + CNT_W'(pix_bit);
    assign sum_x_nxt = (pix_sof ? '0 : sum_x_q) + (pix_bit ? ACC_W'(col_base) : '0);
    assign sum_y_nxt = (pix_sof ? '0 : sum_y_q) + (pix_bit ? ACC_W'(row_base) : '0);

`ifdef CENTROID_ROUND_EN
    assign rnd_nxt = ACC_W'(count_nxt >> 1);
    assign rnd_q   = ACC_W'(count_q >> 1);
`else
    assign rnd_nxt = '0;
    assign rnd_q   = '0;
`endif

    // Restoring divider step: shift dividend MSB into remainder, quotient bit enters dq LSB.
    assign rem_sh         = {rem_q, dq_q[ACC_W-1]};
    assign div_ge         = (rem_sh >= {1'b0, count_q});
    assign rem_diff       = rem_sh - {1'b0, count_q};
    assign rem_nxt        = div_ge ? rem_diff[CNT_W-1:0] : rem_sh[CNT_W-1:0];
    assign unused_rem_msb = rem_diff[CNT_W];
    assign dq_nxt         = {dq_q[ACC_W-2:0], div_ge};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        pix_ready = 1'b0;
        busy      = 1'b0;
        case (state_q)
            IDLE: begin
                pix_ready = 1'b1;
                if (accept && pix_sof) state_d = ACCUM;
            end
            ACCUM: begin
                pix_ready = 1'b1;
                if (accept && !pix_sof && last_pix) state_d = DIV_X;
            end
            DIV_X: begin
                busy = 1'b1;
                if (div_last) state_d = DIV_Y;
            end
            DIV_Y: begin
                busy = 1'b1;
                if (div_last) state_d = DONE;
            end
            DONE: begin
                busy    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign state_dbg = state_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_q        <= '0;
            row_q        <= '0;
            count_q      <= '0;
            sum_x_q      <= '0;
            sum_y_q      <= '0;
            dq_q         <= '0;
            rem_q        <= '0;
            iter_q       <= '0;
            qx_q         <= '0;
            qy_q         <= '0;
            x            <= '0;
            y            <= '0;
            found        <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            case (state_q)
                IDLE, ACCUM: begin
                    if (take) begin
                        col_q   <= col_nxt;
                        row_q   <= row_nxt;
                        count_q <= count_nxt;
                        sum_x_q <= sum_x_nxt;
                        sum_y_q <= sum_y_nxt;
                    end
                    // Latch the x operand including the final pixel's contribution.
                    if (state_q == ACCUM && accept && !pix_sof && last_pix) begin
                        dq_q   <= sum_x_nxt + rnd_nxt;
                        rem_q  <= '0;
                        iter_q <= '0;
                    end
                end
                DIV_X: begin
                    iter_q <= iter_q + ITER_W'(1);
                    if (div_last) begin
                        qx_q   <= dq_nxt[10:0];
                        dq_q   <= sum_y_q + rnd_q;
                        rem_q  <= '0;
                    end else begin
                        dq_q   <= dq_nxt;
                        rem_q  <= rem_nxt;
                    end
                end
                DIV_Y: begin
                    iter_q <= iter_q + ITER_W'(1);
                    dq_q   <= dq_nxt;
                    rem_q  <= rem_nxt;
                    if (div_last) qy_q <= dq_nxt[10:0];
                end
                DONE: begin
                    // An empty frame divided by zero; its quotient is meaningless.
                    x            <= (count_q != '0) ? qx_q : '0;
                    y            <= (count_q != '0) ? qy_q : '0;
                    found        <= (count_q != '0);
                    result_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_centroid_ctrl.sv
// Directed bench for centroid_ctrl on a reduced 64x32 raster so full frames stay short.
module tb_centroid_ctrl;

    localparam int W    = 64;
    localparam int H    = 32;
    localparam int NPIX = W * H;

    logic        clk = 1'b0;
    logic        reset;
    logic        pix_valid, pix_sof, pix_bit;
    logic        pix_ready, busy, result_valid, found;
    logic [10:0] x, y;
    logic [2:0]  state_dbg;

    int checks = 0;
    int errors = 0;
    logic mask [NPIX];

    centroid_ctrl #(.WIDTH(W), .HEIGHT(H), .ACC_W(32), .CNT_W(19)) dut (
        .clk(clk), .reset(reset), .pix_valid(pix_valid), .pix_sof(pix_sof),
        .pix_bit(pix_bit), .pix_ready(pix_ready), .busy(busy),
        .result_valid(result_valid), .found(found), .x(x), .y(y),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_mask();
        for (int i = 0; i < NPIX; i++) mask[i] = 1'b0;
    endtask

    task automatic set_px(input int c, input int r);
        mask[r * W + c] = 1'b1;
    endtask

    // Streams npix raster pixels back-to-back; returns just after the last accepting edge.
    task automatic drive_frame(input int npix);
        for (int i = 0; i < npix; i++) begin
            @(negedge clk);
            pix_valid = 1'b1;
            pix_sof   = (i == 0);
            pix_bit   = mask[i];
            @(posedge clk);
        end
    endtask

    task automatic wait_result(input string tag, input int ex, input int ey,
                               input logic ef, input logic hold);
        int lat     = -1;
        int busy_n  = 0;
        int ready_n = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (result_valid === 1'b1) begin
                lat = k;
                pix_valid = 1'b0; pix_sof = 1'b0; pix_bit = 1'b0;
                break;
            end
            if (busy === 1'b1) busy_n++;
            if (pix_ready !== 1'b0) ready_n++;
            pix_valid = hold; pix_sof = hold; pix_bit = hold;
        end
        check({tag, "_latency"}, lat, 65);
        check({tag, "_busy_cycles"}, busy_n, 65);
        check({tag, "_ready_while_busy"}, ready_n, 0);
        check({tag, "_x"}, 32'(x), ex);
        check({tag, "_y"}, 32'(y), ey);
        check({tag, "_found"}, 32'(found), 32'(ef));
        @(negedge clk);
        check({tag, "_strobe_low"}, 32'(result_valid), 0);
        check({tag, "_busy_low"}, 32'(busy), 0);
        check({tag, "_ready_high"}, 32'(pix_ready), 1);
        check({tag, "_x_held"}, 32'(x), ex);
    endtask

    initial begin
        reset = 1'b1; pix_valid = 1'b0; pix_sof = 1'b0; pix_bit = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_x", 32'(x), 0);
        check("rst_y", 32'(y), 0);
        check("rst_found", 32'(found), 0);
        check("rst_valid", 32'(result_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_ready", 32'(pix_ready), 1);
        check("rst_state", 32'(state_dbg), 0);
        reset = 1'b0;

        clear_mask(); set_px(50, 20);
        drive_frame(NPIX);
        wait_result("single", 50, 20, 1'b1, 1'b0);

        clear_mask();
        drive_frame(NPIX);
        wait_result("empty", 0, 0, 1'b0, 1'b0);

        clear_mask(); set_px(10, 20); set_px(11, 20);
        drive_frame(NPIX);
`ifdef CENTROID_ROUND_EN
        wait_result("pair", 11, 20, 1'b1, 1'b0);
`else
        wait_result("pair", 10, 20, 1'b1, 1'b0);
`endif

        // sums x=21, y=12 over 3 pixels; both modes give (7,4)
        clear_mask(); set_px(2, 3); set_px(7, 9); set_px(12, 0);
        drive_frame(NPIX);
        wait_result("hold", 7, 4, 1'b1, 1'b1);

        clear_mask(); set_px(5, 3);
        drive_frame(500);
        @(negedge clk);
        pix_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("arst_x", 32'(x), 0);
        check("arst_y", 32'(y), 0);
        check("arst_found", 32'(found), 0);
        check("arst_valid", 32'(result_valid), 0);
        check("arst_busy", 32'(busy), 0);
        check("arst_ready", 32'(pix_ready), 1);
        check("arst_state", 32'(state_dbg), 0);
        @(negedge clk);
        reset = 1'b0;
        clear_mask(); set_px(30, 25);
        drive_frame(NPIX);
        wait_result("after_rst", 30, 25, 1'b1, 1'b0);

        clear_mask(); set_px(5, 5);
        drive_frame(1000);
        clear_mask(); set_px(40, 10);
        drive_frame(NPIX);
        wait_result("abort", 40, 10, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
